// File: rtl/keccak_round_sequencer.sv
// keccak_round_sequencer: round counter and LFSR round-constant source for Keccak-f[b],
// with a START/ABORT/DONE handshake and optional two-rounds-per-cycle output.
module keccak_round_sequencer #(
   parameter int LANE_W = 64,
   parameter int UNROLL = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              START,
   input  logic              ABORT,
   output logic              BUSY,
   output logic              WAIT_FOR_NEW_MESSAGE,
   output logic [4:0]        ROUND_IDX,
   output logic [LANE_W-1:0] RC0,
   output logic [LANE_W-1:0] RC1,
   output logic              FIRST,
   output logic              LAST,
   output logic              DONE
);
   localparam int NR = 12 + 2 * $clog2(LANE_W);
   localparam logic [4:0] LAST_IDX = 5'(NR - UNROLL);
   localparam logic [4:0] STEP = 5'(UNROLL);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic done_q, done_d;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return s[7] ? {s[6:0], 1'b0} ^ 8'h71 : {s[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
      logic [7:0] t;
      t = s;
      for (int i = 0; i < n; i++) t = lfsr_step(t);
      return t;
   endfunction

   // the round's seven LFSR output bits land on lane bits 0,1,3,7,15,31,63
   function automatic logic [LANE_W-1:0] round_const(input logic [7:0] s);
      logic [63:0] rc;
      logic [7:0] t;
      rc = '0;
      t = s;
      for (int j = 0; j < 7; j++) begin
         rc[(1 << j) - 1] = t[0];
         t = lfsr_step(t);
      end
      return LANE_W'(rc);
   endfunction

   assign BUSY = state_q == RUN;
   assign WAIT_FOR_NEW_MESSAGE = !BUSY;
   assign ROUND_IDX = idx_q;
   assign FIRST = BUSY && idx_q == 5'd0;
   assign LAST = BUSY && idx_q == LAST_IDX;
   assign DONE = done_q;
   assign RC0 = BUSY ? round_const(lfsr_q) : '0;
   assign RC1 = (BUSY && UNROLL == 2) ? round_const(lfsr_adv(lfsr_q, 7)) : '0;

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      lfsr_d = lfsr_q;
      done_d = 1'b0;
      if (CE) begin
         if (START && !(BUSY && ABORT)) begin
            state_d = RUN;
            idx_d = '0;
            lfsr_d = 8'h01;
         end else if (BUSY && (ABORT || LAST)) begin
            state_d = IDLE;
            idx_d = '0;
            lfsr_d = 8'h01;
            done_d = !ABORT;
         end else if (BUSY) begin
            idx_d = idx_q + STEP;
            lfsr_d = lfsr_adv(lfsr_q, 7 * UNROLL);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q <= '0;
         lfsr_q <= 8'h01;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         lfsr_q <= lfsr_d;
         done_q <= done_d;
      end
   end
endmodule
